muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It consumes the same forwarded operand pair the forwarding unit drives into the ALU (op1/op2). It runs a radix-2 shift-add multiply or restoring divide over 32 cycles, and holds a stall request so the hazard logic freezes IF/ID/EX until the result is ready. Its result joins the ALU result on the EX/MEM path.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/muldiv_sign.sv | 60 ++++++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32M multiply/divide unit.
package rv_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling around the unsigned iterative core: operand magnitudes, result sign,
// divide special cases, and the final conditional negate with high/low select.
module muldiv_sign
   import rv_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [2:0]   funct3_i,
   input  logic [W-1:0] op1_i,
   input  logic [W-1:0] op2_i,
   output logic [W-1:0] abs1_o,
   output logic [W-1:0] abs2_o,
   output logic         neg_o,
   output logic         special_o,
   output logic [W-1:0] special_res_o,
   input  logic [2:0]   post_funct3_i,
   input  logic         post_neg_i,
   input  logic [W-1:0] post_hi_i,
   input  logic [W-1:0] post_lo_i,
   output logic [W-1:0] result_o
);

   logic           s1, s2, n1, n2, is_div, is_rem, ovf;
   logic [2*W-1:0] val, res;

   always_comb begin
      s1     = funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
      s2     = funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
      n1     = s1 & op1_i[W-1];
      n2     = s2 & op2_i[W-1];
      abs1_o = n1 ? -op1_i : op1_i;
      abs2_o = n2 ? -op2_i : op2_i;
      is_div = funct3_i[2];
      is_rem = funct3_i[2] & funct3_i[1];
      // Remainder takes the dividend's sign; products and quotients use the XOR.
      neg_o  = is_rem ? n1 : (n1 ^ n2);
      ovf    = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
               (op1_i == INT_MIN) && (op2_i == NEG_ONE);
      special_o     = is_div && ((op2_i == '0) || ovf);
      special_res_o = '0;
      if (op2_i == '0) begin
         special_res_o = is_rem ? op1_i : '1;
      end else if (ovf) begin
         special_res_o = is_rem ? '0 : INT_MIN;
      end
   end

   always_comb begin
      if (!post_funct3_i[2]) begin
         val = {post_hi_i, post_lo_i};
      end else if (post_funct3_i[1]) begin
         val = {{W{1'b0}}, post_hi_i};
      end else begin
         val = {{W{1'b0}}, post_lo_i};
      end
      res      = post_neg_i ? -val : val;
      result_o = (!post_funct3_i[2] && post_funct3_i != F3_MUL) ? res[2*W-1:W] : res[W-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle over 32 cycles, with a pipeline stall request while working.
module muldiv_unit
   import rv_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [2:0]   i_funct3,
   input  logic         i_flush,
   input  logic [W-1:0] i_op1,
   input  logic [W-1:0] i_op2,
   output logic         o_stall,
   output logic         o_valid,
   output logic [W-1:0] o_result
);

   muldiv_state_t state_q, state_d;
   logic [2:0]    funct3_q, funct3_d;
   logic          neg_q, neg_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [W:0]    acc_q, acc_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;

   logic [W-1:0]  abs1, abs2, special_res, post_result;
   logic          neg, special, accept;
   logic [W:0]    mul_sum, div_shift, div_sub;
   logic          div_ge;

   muldiv_sign #(
      .W(W)
   ) u_sign (
      .funct3_i      (i_funct3),
      .op1_i         (i_op1),
      .op2_i         (i_op2),
      .abs1_o        (abs1),
      .abs2_o        (abs2),
      .neg_o         (neg),
      .special_o     (special),
      .special_res_o (special_res),
      .post_funct3_i (funct3_q),
      .post_neg_i    (neg_q),
      .post_hi_i     (acc_d[W-1:0]),
      .post_lo_i     (lo_d),
      .result_o      (post_result)
   );

   assign accept = (state_q == IDLE) && i_start && !i_flush;

   // Iteration datapath: {acc, lo} is the product shifter for multiply; for divide acc is
   // the partial remainder and lo holds the dividend with quotient bits shifting in.
   always_comb begin
      funct3_d  = funct3_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      b_d       = b_q;
      mul_sum   = acc_q + {1'b0, (lo_q[0] ? b_q : {W{1'b0}})};
      div_shift = {acc_q[W-1:0], lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      div_sub   = div_shift - {1'b0, b_q};
      if (accept) begin
         funct3_d = i_funct3;
         neg_d    = neg;
         cnt_d    = 5'd31;
         acc_d    = '0;
         lo_d     = abs1;
         b_d      = abs2;
      end else if (state_q == BUSY) begin
         cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
         if (!funct3_q[2]) begin
            acc_d = {1'b0, mul_sum[W:1]};
            lo_d  = {mul_sum[0], lo_q[W-1:1]};
         end else begin
            acc_d = div_ge ? div_sub : div_shift;
            lo_d  = {lo_q[W-2:0], div_ge};
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      o_stall  = 1'b0;
      o_valid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               o_stall = 1'b1;
               if (special) begin
                  state_d  = DONE;
                  result_d = special_res;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            o_stall = 1'b1;
            if (cnt_q == 5'd0) begin
               state_d  = DONE;
               result_d = post_result;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (i_flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         funct3_q <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed, special-case, random, abort and
// back-to-back scenarios against a plain-arithmetic reference model.
module tb_muldiv_unit;
   import rv_pkg::*;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        start  = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic        flush  = 1'b0;
   logic [31:0] op1    = '0;
   logic [31:0] op2    = '0;
   logic        stall, valid;
   logic [31:0] result;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_res = '0;

   muldiv_unit #(
      .W(32)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .i_funct3 (funct3),
      .i_flush  (flush),
      .i_op1    (op1),
      .i_op2    (op2),
      .o_stall  (stall),
      .o_valid  (valid),
      .o_result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_muldiv(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      p  = '0;
      r  = '0;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; end
         end
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (b == 32'd0) r = a;
            else begin p = ua % ub; r = p[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f >= 3'd4 && b == 32'd0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Launches one op and watches until o_valid; vcyc is the cycle of o_valid
   // (cycle 0 = the start cycle), stalls counts stall-high cycles up to and including it.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int vcyc, output int stalls);
      res    = '0;
      vcyc   = -1;
      stalls = 0;
      @(posedge clk); #1;
      start  = 1'b1;
      funct3 = f;
      op1    = a;
      op2    = b;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (valid) begin
            vcyc = k;
            res  = result;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
      n_checks++;
      if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
      n_checks++;
      if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (valid !== 1'b0) $display("FAIL idle_valid got %b want 0", valid); else n_pass++;
      n_checks++;
      if (stall !== 1'b0) $display("FAIL idle_stall got %b want 0", stall); else n_pass++;
   endtask

   task automatic test_directed();
      logic [2:0]  tf [8] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU,
                              F3_DIVU, F3_REMU, F3_DIV, F3_REM};
      logic [31:0] ta [8] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] tb [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd7, 32'd7, 32'd2, 32'd2};
      logic [31:0] te [8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] res;
      int          vc, st;
      for (int i = 0; i < 8; i++) begin
         do_op(tf[i], ta[i], tb[i], res, vc, st);
         n_checks++;
         if (res !== te[i]) $display("FAIL dir_%0d_result got %h want %h", i, res, te[i]);
         else n_pass++;
         n_checks++;
         if (vc !== 33) $display("FAIL dir_%0d_valid_cycle got %0d want 33", i, vc);
         else n_pass++;
         n_checks++;
         if (st !== 33) $display("FAIL dir_%0d_stall_cycles got %0d want 33", i, st);
         else n_pass++;
         last_res = te[i];
      end
   endtask

   task automatic test_special();
      logic [2:0]  tf [6] = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
      logic [31:0] ta [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                              32'h1234_5678, 32'h1234_5678};
      logic [31:0] tb [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] te [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                              32'hFFFF_FFFF, 32'h1234_5678};
      logic [31:0] res;
      int          vc, st;
      for (int i = 0; i < 6; i++) begin
         do_op(tf[i], ta[i], tb[i], res, vc, st);
         n_checks++;
         if (res !== te[i]) $display("FAIL spc_%0d_result got %h want %h", i, res, te[i]);
         else n_pass++;
         n_checks++;
         if (vc !== 1) $display("FAIL spc_%0d_valid_cycle got %0d want 1", i, vc);
         else n_pass++;
         n_checks++;
         if (st !== 1) $display("FAIL spc_%0d_stall_cycles got %0d want 1", i, st);
         else n_pass++;
         last_res = te[i];
      end
   endtask

   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, res, exp;
      int          vc, st, lat;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(7, 0));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(9, 0))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(9, 1));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         exp = ref_muldiv(f, a, b);
         lat = ref_latency(f, a, b);
         do_op(f, a, b, res, vc, st);
         n_checks++;
         if (res !== exp)
            $display("FAIL rand_%0d f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, exp);
         else n_pass++;
         n_checks++;
         if (vc !== lat) $display("FAIL rand_%0d_valid_cycle got %0d want %0d", i, vc, lat);
         else n_pass++;
         last_res = exp;
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          vc, st, seen;
      @(posedge clk); #1;
      start  = 1'b1;
      funct3 = F3_DIVU;
      op1    = 32'd1000;
      op2    = 32'd3;
      repeat (10) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1) $display("FAIL flush_busy_stall got %b want 1", stall); else n_pass++;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else n_pass++;
      n_checks++;
      if (valid !== 1'b0) $display("FAIL flush_valid got %b want 0", valid); else n_pass++;
      n_checks++;
      if (result !== last_res) $display("FAIL flush_result got %h want %h", result, last_res);
      else n_pass++;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) seen++;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL flush_no_valid got %0d pulses want 0", seen); else n_pass++;
      do_op(F3_DIVU, 32'd9, 32'd3, res, vc, st);
      n_checks++;
      if (res !== 32'd3) $display("FAIL flush_fresh_result got %h want 3", res); else n_pass++;
      n_checks++;
      if (vc !== 33) $display("FAIL flush_fresh_cycle got %0d want 33", vc); else n_pass++;
      last_res = 32'd3;
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int          vc, st;
      @(posedge clk); #1;
      start  = 1'b1;
      funct3 = F3_MUL;
      op1    = 32'd123456;
      op2    = 32'd789;
      repeat (20) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (result !== 32'd0) $display("FAIL rstmid_result got %h want 0", result); else n_pass++;
      n_checks++;
      if (valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid); else n_pass++;
      n_checks++;
      if (stall !== 1'b0) $display("FAIL rstmid_stall got %b want 0", stall); else n_pass++;
      do_op(F3_DIVU, 32'd9, 32'd3, res, vc, st);
      n_checks++;
      if (res !== 32'd3) $display("FAIL rstmid_fresh_result got %h want 3", res); else n_pass++;
      n_checks++;
      if (vc !== 33) $display("FAIL rstmid_fresh_cycle got %0d want 33", vc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, exp;
      int          first, prev, count, bad_gap, bad_res, bad_stall;
      a       = $urandom();
      b       = {1'b0, 31'($urandom())} | 32'd1;
      exp     = ref_muldiv(F3_DIV, a, b);
      first   = -1;
      prev    = -1;
      count   = 0;
      bad_gap = 0;
      bad_res = 0;
      bad_stall = 0;
      @(posedge clk); #1;
      start  = 1'b1;
      funct3 = F3_DIV;
      op1    = a;
      op2    = b;
      for (int k = 0; k < 111; k++) begin
         @(negedge clk);
         if (stall === valid) bad_stall++;
         if (valid) begin
            count++;
            if (first < 0) first = k;
            if (prev >= 0 && k - prev != 34) bad_gap++;
            if (result !== exp) bad_res++;
            prev = k;
         end
      end
      start = 1'b0;
      n_checks++;
      if (first !== 33) $display("FAIL b2b_first got %0d want 33", first); else n_pass++;
      n_checks++;
      if (count !== 3) $display("FAIL b2b_count got %0d want 3", count); else n_pass++;
      n_checks++;
      if (bad_gap !== 0) $display("FAIL b2b_interval got %0d bad want 0", bad_gap); else n_pass++;
      n_checks++;
      if (bad_res !== 0) $display("FAIL b2b_result got %0d bad want 0 (exp %h)", bad_res, exp);
      else n_pass++;
      n_checks++;
      if (bad_stall !== 0) $display("FAIL b2b_stall got %0d bad want 0", bad_stall);
      else n_pass++;
      repeat (40) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
